// File: rtl/bdd_tree_loader_pkg.sv
// Shared definitions for the BDD tree image loader and the traversal engine:
// frame constants, node/link word widths and the loader state encoding.
package bdd_tree_loader_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam int         REC_BYTES   = 9;
    localparam int         NODE_W      = 56;
    localparam int         LINK_W      = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        REC   = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_e;

    // One step of the byte-wise XOR frame checksum.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // States in which the loader can take an inbound byte.
    function automatic logic ready_in(input state_e st);
        logic rdy;
        case (st)
            IDLE, COUNT, REC, CSUM: rdy = 1'b1;
            default:                rdy = 1'b0;
        endcase
        return rdy;
    endfunction

endpackage

// File: rtl/bdd_loader_asm.sv
// Record assembly: shifts node bytes MSB-first into the node word, captures the
// link word from bytes 7-8 and keeps the running XOR checksum of record bytes.
module bdd_loader_asm
    import bdd_tree_loader_pkg::*;
#(
    parameter int NODE_WIDTH = 56,
    parameter int LINK_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [3:0]            byte_idx,
    input  logic [7:0]            data,
    output logic [NODE_WIDTH-1:0] word_a,
    output logic [LINK_WIDTH-1:0] word_b,
    output logic [7:0]            csum
);

    logic [NODE_WIDTH-1:0] word_a_r;
    logic [LINK_WIDTH-1:0] word_b_r;
    logic [7:0]            csum_r;

    // Byte capture and checksum accumulation for each accepted record byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_a_r <= '0;
            word_b_r <= '0;
            csum_r   <= 8'h00;
        end else if (clr) begin
            word_a_r <= '0;
            word_b_r <= '0;
            csum_r   <= 8'h00;
        end else if (en) begin
            csum_r <= csum_step(csum_r, data);
            if (byte_idx < 4'(REC_BYTES - 2)) begin
                word_a_r <= {word_a_r[NODE_WIDTH-9:0], data};
            end else if (byte_idx == 4'(REC_BYTES - 2)) begin
                // Only the low bits of byte 7 belong to the link word.
                word_b_r[LINK_WIDTH-1:8] <= data[LINK_WIDTH-9:0];
            end else begin
                word_b_r[7:0] <= data;
            end
        end
    end

    assign word_a = word_a_r;
    assign word_b = word_b_r;
    assign csum   = csum_r;

endmodule

// File: rtl/bdd_tree_loader.sv
// Streams a BDD node image (header, count, 9-byte records, XOR checksum) into the
// node and link memories and flags a resident, checksum-good tree.
module bdd_tree_loader
    import bdd_tree_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int NODE_WIDTH = 56,
    parameter int LINK_WIDTH = 12,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [NODE_WIDTH-1:0] mem_wdata_a,
    output logic [LINK_WIDTH-1:0] mem_wdata_b,
    output logic                  busy,
    output logic                  tree_valid,
    output logic                  load_err
);

    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    state_e                state_r;
    state_e                state_nxt_s;
    logic                  s_ready_r;
    logic                  busy_r;
    logic                  mem_we_r;
    logic                  tree_valid_r;
    logic                  load_err_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [7:0]            rec_left_r;
    logic [3:0]            byte_idx_r;

    logic                  xfer_s;
    logic                  count_ok_s;
    logic                  nib_err_s;
    logic                  last_byte_s;
    logic                  hdr_start_s;
    logic                  asm_clr_s;
    logic                  asm_en_s;
    logic [7:0]            csum_s;

    assign xfer_s      = s_valid & s_ready_r;
    assign count_ok_s  = (s_data != 8'd0) && ({1'b0, s_data} <= DEPTH_L);
    assign nib_err_s   = (byte_idx_r == 4'(REC_BYTES - 2)) && (s_data[7:4] != 4'd0);
    assign last_byte_s = (byte_idx_r == 4'(REC_BYTES - 1));
    assign hdr_start_s = (state_r == IDLE) && (state_nxt_s == COUNT);
    assign asm_clr_s   = (state_r == COUNT) && xfer_s;
    assign asm_en_s    = (state_r == REC) && xfer_s;

    bdd_loader_asm #(
        .NODE_WIDTH (NODE_WIDTH),
        .LINK_WIDTH (LINK_WIDTH)
    ) u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (asm_clr_s),
        .en       (asm_en_s),
        .byte_idx (byte_idx_r),
        .data     (s_data),
        .word_a   (mem_wdata_a),
        .word_b   (mem_wdata_b),
        .csum     (csum_s)
    );

    // Next-state decode; every waiting state simply holds while s_valid is low.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (xfer_s && (s_data == HEADER_BYTE)) state_nxt_s = COUNT;
                else                                   state_nxt_s = IDLE;
            end
            COUNT: begin
                if (xfer_s) state_nxt_s = count_ok_s ? REC : ERR;
                else        state_nxt_s = COUNT;
            end
            REC: begin
                if (xfer_s && nib_err_s)        state_nxt_s = ERR;
                else if (xfer_s && last_byte_s) state_nxt_s = WRITE;
                else                            state_nxt_s = REC;
            end
            WRITE: begin
                if (rec_left_r == 8'd1) state_nxt_s = CSUM;
                else                    state_nxt_s = REC;
            end
            CSUM: begin
                if (xfer_s) state_nxt_s = (s_data == csum_s) ? DONE : ERR;
                else        state_nxt_s = CSUM;
            end
            DONE:    state_nxt_s = IDLE;
            ERR:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            s_ready_r    <= 1'b0;
            busy_r       <= 1'b0;
            mem_we_r     <= 1'b0;
            tree_valid_r <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            s_ready_r <= ready_in(state_nxt_s);
            busy_r    <= (state_nxt_s != IDLE);
            mem_we_r  <= (state_nxt_s == WRITE);
            if (state_nxt_s == DONE) begin
                tree_valid_r <= 1'b1;
            end else if (hdr_start_s) begin
                tree_valid_r <= 1'b0;
            end
            if (state_nxt_s == ERR) begin
                load_err_r <= 1'b1;
            end else if (hdr_start_s) begin
                load_err_r <= 1'b0;
            end
        end
    end

    // Record bookkeeping; the address stops on the last record so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_r <= '0;
            rec_left_r <= 8'd0;
            byte_idx_r <= 4'd0;
        end else begin
            case (state_r)
                COUNT: begin
                    if (xfer_s) begin
                        rec_left_r <= s_data;
                        mem_addr_r <= '0;
                        byte_idx_r <= 4'd0;
                    end
                end
                REC: begin
                    if (xfer_s) begin
                        byte_idx_r <= last_byte_s ? 4'd0 : byte_idx_r + 4'd1;
                    end
                end
                WRITE: begin
                    rec_left_r <= rec_left_r - 8'd1;
                    if (rec_left_r != 8'd1) begin
                        mem_addr_r <= mem_addr_r + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    rec_left_r <= rec_left_r;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_r;
    assign busy       = busy_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign tree_valid = tree_valid_r;
    assign load_err   = load_err_r;

endmodule
